// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall sequencer: front-end enables, bubbles, flushes, a
// mult/div busy tracker and saturating stall/flush counters.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | mult/div unit free; HI/LO valid
// BUSY    | mult/div in flight; md_cnt_q counts down cycles still owed
module hazard_ctrl #(
  parameter int MD_LATENCY = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_wait,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_md_start,
  input  logic             id_md_read,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_jump,
  input  logic             ex_branch_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

  md_state_t        state_q, state_d;
  logic [7:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic rs_hit;
  logic rt_hit;
  logic lu;
  logic md;
  logic fl;
  logic md_issue;

  // Hazard terms are evaluated on the current ID/EX contents.
  always_comb begin
    rs_hit = id_uses_rs && (id_rs == ex_rt);
    rt_hit = id_uses_rt && (id_rt == ex_rt);
    lu     = ex_memread && (ex_rt != 5'd0) && (rs_hit || rt_hit);
    md     = (state_q == ST_BUSY) && (id_md_read || id_md_start);
    fl     = ex_jump || ex_branch_taken;
  end

  // A mult/div only starts when its instruction really moves into EX.
  assign md_issue = !reset && id_md_start && !mem_wait && !fl && !md && !lu;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      md_cnt_q    <= 8'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (md_issue) begin
          state_d  = ST_BUSY;
          md_cnt_d = 8'(MD_LATENCY);
        end
      end
      ST_BUSY: begin
        // Keeps counting through mem_wait: the unit runs independently.
        if (md_cnt_q == 8'd1) begin
          state_d  = ST_IDLE;
          md_cnt_d = 8'd0;
        end else begin
          md_cnt_d = md_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        md_cnt_d = 8'd0;
      end
    endcase
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (reset) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      idex_en = 1'b0;
    end else if (mem_wait) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      idex_en = 1'b0;
    end else if (fl) begin
      // Wrong-path instructions in IF/ID and ID are squashed; any stall is moot.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (md || lu) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en && !reset && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (ifid_flush && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  assign md_busy   = (state_q == ST_BUSY);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: inputs change on the falling edge and
// everything is checked 1 ns later, well away from the rising edge.
module tb_hazard_ctrl;

  localparam int LAT = 4;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_wait;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          id_uses_rs, id_uses_rt, id_md_start, id_md_read;
  logic          ex_memread, ex_jump, ex_branch_taken;
  logic          pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, md_busy;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int exp_stall   = 0;
  int exp_flush   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_wait        (mem_wait),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_md_start     (id_md_start),
    .id_md_read      (id_md_read),
    .ex_memread      (ex_memread),
    .ex_rt           (ex_rt),
    .ex_jump         (ex_jump),
    .ex_branch_taken (ex_branch_taken),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .ifid_flush      (ifid_flush),
    .idex_en         (idex_en),
    .idex_bubble     (idex_bubble),
    .md_busy         (md_busy),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic pc, input logic ifid,
                         input logic flush, input logic idex, input logic bub);
    chk({tag, ".pc_en"},       32'(pc_en),       32'(pc));
    chk({tag, ".ifid_en"},     32'(ifid_en),     32'(ifid));
    chk({tag, ".ifid_flush"},  32'(ifid_flush),  32'(flush));
    chk({tag, ".idex_en"},     32'(idex_en),     32'(idex));
    chk({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(bub));
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
    chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(exp_flush));
  endtask

  task automatic idle_in();
    mem_wait        = 1'b0;
    id_rs           = 5'd0;
    id_rt           = 5'd0;
    id_uses_rs      = 1'b0;
    id_uses_rt      = 1'b0;
    id_md_start     = 1'b0;
    id_md_read      = 1'b0;
    ex_memread      = 1'b0;
    ex_rt           = 5'd0;
    ex_jump         = 1'b0;
    ex_branch_taken = 1'b0;
  endtask

  task automatic set_lu();
    ex_memread = 1'b1;
    ex_rt      = 5'd5;
    id_rs      = 5'd5;
    id_uses_rs = 1'b1;
  endtask

  initial begin
    // Reset dominates a concurrent jump.
    reset = 1'b1;
    idle_in();
    ex_jump = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_ctl("rst_hold", 0, 0, 0, 0, 0);
    chk("rst_hold.md_busy", 32'(md_busy), 32'd0);
    chk_cnt("rst_hold");

    @(negedge clk);
    reset = 1'b0;
    idle_in();
    #1 chk_ctl("dflt", 1, 1, 0, 1, 0);

    // Load-use on rs.
    @(negedge clk);
    idle_in(); set_lu();
    #1 chk_ctl("lu_rs", 0, 0, 0, 1, 1);
    exp_stall = 1;
    @(negedge clk);
    idle_in();
    #1 chk_ctl("lu_gone", 1, 1, 0, 1, 0);
    chk_cnt("lu_gone");

    // Load into r0 never stalls.
    @(negedge clk);
    idle_in();
    ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    #1 chk_ctl("lu_r0", 1, 1, 0, 1, 0);

    // Load-use on rt.
    @(negedge clk);
    idle_in();
    ex_memread = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
    id_rs = 5'd3; id_uses_rs = 1'b1;
    #1 chk_ctl("lu_rt", 0, 0, 0, 1, 1);
    exp_stall = 2;

    // rt matches but is not read.
    @(negedge clk);
    idle_in();
    ex_memread = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b0;
    #1 chk_ctl("lu_rt_unused", 1, 1, 0, 1, 0);

    // Register match but EX is not a load.
    @(negedge clk);
    idle_in();
    ex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
    #1 chk_ctl("no_load", 1, 1, 0, 1, 0);
    @(negedge clk);
    idle_in();
    #1 chk_cnt("after_lu");

    // Jump beats a load-use in the same cycle.
    @(negedge clk);
    idle_in(); set_lu(); ex_jump = 1'b1;
    #1 chk_ctl("jump_lu", 1, 1, 1, 1, 1);
    exp_flush = 1;

    // Taken branch squashes a mult in ID: no issue.
    @(negedge clk);
    idle_in(); ex_branch_taken = 1'b1; id_md_start = 1'b1;
    #1 chk_ctl("br_md", 1, 1, 1, 1, 1);
    exp_flush = 2;
    @(negedge clk);
    idle_in();
    #1 chk_cnt("after_flush");
    chk("br_md.md_busy", 32'(md_busy), 32'd0);

    // Mult held by a load-use does not issue.
    @(negedge clk);
    idle_in(); set_lu(); id_md_start = 1'b1;
    #1 chk_ctl("md_lu", 0, 0, 0, 1, 1);
    exp_stall = 3;
    @(negedge clk);
    idle_in();
    #1 chk("md_lu.md_busy", 32'(md_busy), 32'd0);
    chk_cnt("md_lu");

    // Mult issue then mfhi held: busy cycles 1..4, read issues at cycle 5.
    @(negedge clk);
    idle_in(); id_md_start = 1'b1;
    #1 chk_ctl("md_issue", 1, 1, 0, 1, 0);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      idle_in(); id_md_read = 1'b1;
      #1 chk($sformatf("md_rd_c%0d.md_busy", k), 32'(md_busy), 32'd1);
      chk_ctl($sformatf("md_rd_c%0d", k), 0, 0, 0, 1, 1);
      exp_stall++;
    end
    @(negedge clk);
    #1 chk("md_rd_c5.md_busy", 32'(md_busy), 32'd0);
    chk_ctl("md_rd_c5", 1, 1, 0, 1, 0);
    chk_cnt("md_rd_c5");

    // mem_wait while BUSY with a load-use (and a jump first): full freeze.
    @(negedge clk);
    idle_in(); id_md_start = 1'b1;
    #1 chk_ctl("mw_issue", 1, 1, 0, 1, 0);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      idle_in(); mem_wait = 1'b1; set_lu();
      if (k == 1) ex_jump = 1'b1;
      #1 chk($sformatf("mw_c%0d.md_busy", k), 32'(md_busy), 32'd1);
      chk_ctl($sformatf("mw_c%0d", k), 0, 0, 0, 0, 0);
      exp_stall++;
    end
    @(negedge clk);
    idle_in();
    #1 chk("mw_c5.md_busy", 32'(md_busy), 32'd0);
    chk_ctl("mw_c5", 1, 1, 0, 1, 0);
    chk_cnt("mw_c5");

    // Back-to-back mult: second start waits, then a fresh busy window.
    @(negedge clk);
    idle_in(); id_md_start = 1'b1;
    #1 chk_ctl("b2b_issue", 1, 1, 0, 1, 0);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      #1 chk($sformatf("b2b_c%0d.md_busy", k), 32'(md_busy), 32'd1);
      chk_ctl($sformatf("b2b_c%0d", k), 0, 0, 0, 1, 1);
      exp_stall++;
    end
    @(negedge clk);
    #1 chk("b2b_c5.md_busy", 32'(md_busy), 32'd0);
    chk_ctl("b2b_c5", 1, 1, 0, 1, 0);
    for (int k = 6; k < 6 + LAT; k++) begin
      @(negedge clk);
      idle_in();
      #1 chk($sformatf("b2b_c%0d.md_busy", k), 32'(md_busy), 32'd1);
      chk_ctl($sformatf("b2b_c%0d", k), 1, 1, 0, 1, 0);
    end
    @(negedge clk);
    #1 chk("b2b_end.md_busy", 32'(md_busy), 32'd0);
    chk_cnt("b2b_end");

    // Clear, then build stall_cnt=7 / flush_cnt=1 with the unit BUSY.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    #1 chk_cnt("rst2");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      idle_in(); set_lu();
    end
    @(negedge clk);
    idle_in(); ex_jump = 1'b1;
    @(negedge clk);
    idle_in(); id_md_start = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      idle_in(); id_md_read = 1'b1;
    end
    exp_stall = 7;
    exp_flush = 1;
    @(negedge clk);
    idle_in(); id_md_read = 1'b1; ex_jump = 1'b1; reset = 1'b1;
    #1 chk_cnt("pre_rst");
    chk("pre_rst.md_busy", 32'(md_busy), 32'd1);
    chk_ctl("rst_mid", 0, 0, 0, 0, 0);
    exp_stall = 0;
    exp_flush = 0;
    @(negedge clk);
    #1 chk("post_rst.md_busy", 32'(md_busy), 32'd0);
    chk_cnt("post_rst");
    chk_ctl("post_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    idle_in();
    #1 chk("rst_rel.md_busy", 32'(md_busy), 32'd0);
    chk_ctl("rst_rel", 1, 1, 0, 1, 0);

    // Saturation of both counters at 8'hFF.
    for (int k = 0; k < 254; k++) begin
      @(negedge clk);
      idle_in(); mem_wait = 1'b1;
    end
    @(negedge clk);
    idle_in();
    exp_stall = 254;
    #1 chk_cnt("stall_254");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle_in(); mem_wait = 1'b1;
    end
    @(negedge clk);
    idle_in();
    exp_stall = 255;
    #1 chk_cnt("stall_sat");
    for (int k = 0; k < 254; k++) begin
      @(negedge clk);
      idle_in(); ex_jump = 1'b1;
    end
    @(negedge clk);
    idle_in();
    exp_flush = 254;
    #1 chk_cnt("flush_254");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle_in(); ex_branch_taken = 1'b1;
    end
    @(negedge clk);
    idle_in();
    exp_flush = 255;
    #1 chk_cnt("flush_sat");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall sequencer for the 5-stage CPU.
- Drives the enable and bubble controls of the PC, the IF/ID register and the ID/EX register.
- Detects load-use hazards and control-flow flushes, and tracks a multi-cycle multiply/divide unit with a busy FSM.
- Keeps saturating stall and flush performance counters.

Parameters:
- MD_LATENCY, 8: cycles the mult/div unit needs after issue before HI/LO are valid (legal range 1..255).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- mem_wait  in  1  data memory not ready; freeze the whole front end.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_md_start  in  1  ID instruction is mult/multu/div/divu.
- id_md_read  in  1  ID instruction is mfhi/mflo.
- ex_memread  in  1  instruction in EX is a load (ID/EX MEMORY read bit).
- ex_rt  in  5  destination rt of the EX-stage instruction.
- ex_jump  in  1  EX-stage jump.
- ex_branch_taken  in  1  EX-stage branch resolved taken.
- pc_en  out  1  PC load enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads zeros (NOP).
- idex_en  out  1  ID/EX load enable.
- idex_bubble  out  1  ID/EX loads zeros, i.e. a bubble.
- md_busy  out  1  mult/div unit busy.
- stall_cnt  out  CNT_W  cycles with pc_en=0, excluding reset.
- flush_cnt  out  CNT_W  cycles with ifid_flush=1.

Behaviour:
- Default outputs (no condition active): pc_en=1, ifid_en=1, idex_en=1, ifid_flush=0, idex_bubble=0.
- Reset dominates all inputs. While reset=1:
  - pc_en=0, ifid_en=0, idex_en=0, ifid_flush=0, idex_bubble=0.
  - On the clock edge: FSM goes to IDLE, md_cnt=0, stall_cnt=0, flush_cnt=0.
- Control outputs are combinational from inputs and registered state, so they take effect in the same cycle.
- Load-use condition `lu`:
  - ex_memread && ex_rt!=0 && ((id_uses_rs && id_rs==ex_rt) || (id_uses_rt && id_rt==ex_rt)).
- Mult/div condition `md`:
  - md_busy && (id_md_read || id_md_start).
- Flush condition `fl`: ex_jump || ex_branch_taken.
- Priority, highest first:
  1. mem_wait: pc_en=0, ifid_en=0, idex_en=0, no bubble, no flush.
  2. fl: pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1. A stall request in the same cycle is discarded.
  3. md: pc_en=0, ifid_en=0, idex_bubble=1.
  4. lu: pc_en=0, ifid_en=0, idex_bubble=1. Lasts exactly one cycle because the load advances to MEM.
- Mult/div FSM, states IDLE and BUSY, with an 8-bit down-counter md_cnt:
  - The issue strobe is id_md_start && !mem_wait && !fl && !md && !lu, i.e. the instruction actually advances into EX.
  - Issue in IDLE: next state BUSY, md_cnt=MD_LATENCY.
  - BUSY: md_cnt decrements every cycle, including during mem_wait.
  - BUSY with md_cnt==1: next state IDLE, md_cnt=0.
  - md_busy = (state==BUSY).
  - A start in BUSY is stalled by `md`, never issued, so the counter is never reloaded mid-operation.
  - md_busy is low in the cycle after the last decrement. A waiting mfhi/mflo issues in that cycle.
- Performance counters:
  - stall_cnt increments each non-reset cycle with pc_en=0.
  - flush_cnt increments each cycle with ifid_flush=1.
  - Both saturate at all-ones.
- Reset mid-operation: the FSM is forced to IDLE and the counters cleared. The pipeline registers' own resets clear the in-flight instructions.
- Latency: zero cycles for all control outputs; one cycle for FSM and counter updates.

Test Plan:
- Load-use: ex_memread=1, ex_rt=5, id_rs=5, id_uses_rs=1 for one cycle -> pc_en=0, ifid_en=0, idex_bubble=1 that cycle, stall_cnt=1 afterwards. Repeat with ex_rt=0 -> no stall.
- Jump flush: ex_jump=1 in the same cycle as a load-use match -> ifid_flush=1, idex_bubble=1, pc_en=1, stall_cnt unchanged, flush_cnt +1.
- Mult/div timing with MD_LATENCY=4:
  - Issue id_md_start at cycle 0 -> md_busy=1 in cycles 1..4, 0 at cycle 5.
  - id_md_read held from cycle 1 -> stalled in cycles 1..4, issues at cycle 5, stall_cnt=4.
- mem_wait: mem_wait=1 while md BUSY with a load-use present -> pc_en=ifid_en=idex_en=0, idex_bubble=0. md_cnt still reaches 0 after MD_LATENCY cycles.
- Back-to-back mult: second id_md_start while BUSY -> stalled until md_busy falls, then issues and md_busy rises again for MD_LATENCY cycles.
- Reset: assert reset during BUSY with stall_cnt=7 -> next cycle md_busy=0, stall_cnt=0, flush_cnt=0. Outputs match the reset values while reset is held.
